// File: rtl/hazard_fwd_unit_pkg.sv
// Shared definitions for the hazard/forwarding controller.
//   - forwarding select encodings (register file, or stage k at FWD_STG0 + k)
//   - stage index constants (stage 0 is EXE, the youngest result producer)
//   - pipeline mode enumeration used to decode stage enables/clears
//   - helper that sizes the forwarding select field
package hazard_fwd_unit_pkg;

    localparam int ADDR_W_DEF = 5;

    localparam int FWD_RF   = 0;  // operand comes from the register file
    localparam int FWD_STG0 = 1;  // stage k result selected as FWD_STG0 + k

    localparam int STG_EXE  = 0;  // youngest forwarding stage

    // One mode per cycle; its precedence is hold > flush > stall > run.
    typedef enum logic [1:0] {
        MODE_RUN,
        MODE_STALL,
        MODE_FLUSH,
        MODE_HOLD
    } pipe_mode_e;

    function automatic int fwd_sel_w(input int num_fwd);
        return $clog2(num_fwd + 1);
    endfunction

endpackage

// File: rtl/hazard_fwd_unit_if.sv
// Bus between the pipeline (master) and the hazard/forwarding unit (slave).
//   master drives: debug controls, ID operand info, downstream write info,
//                  branch_taken
//   slave drives:  forwarding selects, fwd_m, stage enables/clears,
//                  mdu_busy, stall/flush performance counters
interface hazard_fwd_unit_if
    import hazard_fwd_unit_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int NUM_FWD = 2,
    parameter int CNT_W   = 32
);
    localparam int SEL_W = fwd_sel_w(NUM_FWD);

    logic                      debug_en;
    logic                      debug_step;
    logic [ADDR_W-1:0]         id_rs_addr;
    logic [ADDR_W-1:0]         id_rt_addr;
    logic                      id_rs_used;
    logic                      id_rt_used;
    logic                      id_is_store;
    logic                      id_is_mdu;
    logic [ADDR_W-1:0]         id_mdu_dst;
    logic [NUM_FWD-1:0]        stg_wen;
    logic [NUM_FWD*ADDR_W-1:0] stg_waddr;
    logic [NUM_FWD-1:0]        stg_is_load;
    logic                      branch_taken;

    logic [SEL_W-1:0]          fwd_a_sel;
    logic [SEL_W-1:0]          fwd_b_sel;
    logic                      fwd_m;
    logic                      if_en, id_en, exe_en, mem_en, wb_en;
    logic                      if_rst, id_rst, exe_rst, mem_rst, wb_rst;
    logic                      mdu_busy;
    logic [CNT_W-1:0]          stall_cnt;
    logic [CNT_W-1:0]          flush_cnt;

    modport master (
        output debug_en, debug_step, id_rs_addr, id_rt_addr, id_rs_used,
               id_rt_used, id_is_store, id_is_mdu, id_mdu_dst, stg_wen,
               stg_waddr, stg_is_load, branch_taken,
        input  fwd_a_sel, fwd_b_sel, fwd_m, if_en, id_en, exe_en, mem_en,
               wb_en, if_rst, id_rst, exe_rst, mem_rst, wb_rst, mdu_busy,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  debug_en, debug_step, id_rs_addr, id_rt_addr, id_rs_used,
               id_rt_used, id_is_store, id_is_mdu, id_mdu_dst, stg_wen,
               stg_waddr, stg_is_load, branch_taken,
        output fwd_a_sel, fwd_b_sel, fwd_m, if_en, id_en, exe_en, mem_en,
               wb_en, if_rst, id_rst, exe_rst, mem_rst, wb_rst, mdu_busy,
               stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_fwd_unit_mdu_scoreboard.sv
// hfu_mdu_scoreboard: tracks a single in-flight multi-cycle MDU op.
//   issue/issue_dst   latch destination, load the latency counter, set busy
//   advance           pipeline moved this cycle; the counter only ages then
//   rs/rt addr+used, id_is_mdu   instruction currently in ID
//   busy              an MDU op is in flight
//   conflict          ID must stall on the in-flight op
module hfu_mdu_scoreboard #(
    parameter int ADDR_W  = 5,
    parameter int MDU_LAT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue,
    input  logic              advance,
    input  logic [ADDR_W-1:0] issue_dst,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic              rs_used,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic              rt_used,
    input  logic              id_is_mdu,
    output logic              busy,
    output logic              conflict
);
    localparam int CW = $clog2(MDU_LAT + 1);

    logic [CW-1:0]     cnt;
    logic [ADDR_W-1:0] dst;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            dst  <= '0;
            busy <= 1'b0;
        end else if (issue) begin
            cnt  <= CW'(MDU_LAT);
            dst  <= issue_dst;
            busy <= 1'b1;
        end else if (advance && cnt != '0) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) busy <= 1'b0;
        end
    end

    // $0 is hard-wired zero, so reading it never depends on the MDU result.
    assign conflict = busy && ((rs_used && rs_addr != '0 && rs_addr == dst) ||
                               (rt_used && rt_addr != '0 && rt_addr == dst) ||
                               id_is_mdu);

endmodule

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: hazard/forwarding controller beside the ID stage.
//   clk, rst_n  clock and asynchronous active-low reset
//   bus         slave side of hazard_fwd_unit_if: ID operand info and
//               downstream write info in; forwarding selects, stage
//               enables/clears, mdu_busy and performance counters out.
module hazard_fwd_unit
    import hazard_fwd_unit_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int NUM_FWD = 2,
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 32
) (
    input logic              clk,
    input logic              rst_n,
    hazard_fwd_unit_if.slave bus
);
    localparam int SEL_W = fwd_sel_w(NUM_FWD);

    logic [SEL_W-1:0] a_stage, b_stage;
    logic             a_hit, b_hit, a_load, b_load;

    // NOTE: combinational blocks use blocking assignments and give every
    // output a default first, so no path leaves a variable unassigned (latch).
    always_comb begin
        a_hit   = 1'b0;
        b_hit   = 1'b0;
        a_load  = 1'b0;
        b_load  = 1'b0;
        a_stage = '0;
        b_stage = '0;
        // Scan oldest to youngest so the youngest matching stage wins.
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (bus.stg_wen[k] && bus.stg_waddr[k*ADDR_W +: ADDR_W] == bus.id_rs_addr) begin
                a_hit   = 1'b1;
                a_stage = SEL_W'(k);
                a_load  = bus.stg_is_load[k];
            end
            if (bus.stg_wen[k] && bus.stg_waddr[k*ADDR_W +: ADDR_W] == bus.id_rt_addr) begin
                b_hit   = 1'b1;
                b_stage = SEL_W'(k);
                b_load  = bus.stg_is_load[k];
            end
        end
    end

    logic a_need, b_need, a_ld_exe, b_ld_exe, fwd_m_c, load_stall;
    logic [SEL_W-1:0] sel_a_c, sel_b_c;

    assign a_need   = bus.id_rs_used && bus.id_rs_addr != '0 && a_hit;
    assign b_need   = bus.id_rt_used && bus.id_rt_addr != '0 && b_hit;
    assign a_ld_exe = a_need && a_stage == SEL_W'(STG_EXE) && a_load;
    assign b_ld_exe = b_need && b_stage == SEL_W'(STG_EXE) && b_load;
    // Store data is only needed in MEM, where the load result is available.
    assign fwd_m_c    = b_ld_exe && bus.id_is_store;
    assign load_stall = a_ld_exe || (b_ld_exe && !bus.id_is_store);
    assign sel_a_c    = a_need ? a_stage + SEL_W'(FWD_STG0) : SEL_W'(FWD_RF);
    assign sel_b_c    = (b_need && !fwd_m_c) ? b_stage + SEL_W'(FWD_STG0) : SEL_W'(FWD_RF);

    logic       step_prev, hold, mdu_stall, mdu_busy;
    pipe_mode_e mode;

    // A step request counts only on its rising edge, so a held step
    // advances exactly one cycle.
    assign hold = bus.debug_en && !(bus.debug_step && !step_prev);

    always_comb begin
        if (hold)                          mode = MODE_HOLD;
        else if (bus.branch_taken)         mode = MODE_FLUSH;
        else if (load_stall || mdu_stall)  mode = MODE_STALL;
        else                               mode = MODE_RUN;
    end

    hfu_mdu_scoreboard #(
        .ADDR_W  (ADDR_W),
        .MDU_LAT (MDU_LAT)
    ) u_mdu_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .issue     (mode == MODE_RUN && bus.id_is_mdu),
        .advance   (mode != MODE_HOLD),
        .issue_dst (bus.id_mdu_dst),
        .rs_addr   (bus.id_rs_addr),
        .rs_used   (bus.id_rs_used),
        .rt_addr   (bus.id_rt_addr),
        .rt_used   (bus.id_rt_used),
        .id_is_mdu (bus.id_is_mdu),
        .busy      (mdu_busy),
        .conflict  (mdu_stall)
    );

    always_comb begin
        bus.if_en     = 1'b1;
        bus.id_en     = 1'b1;
        bus.exe_en    = 1'b1;
        bus.mem_en    = 1'b1;
        bus.wb_en     = 1'b1;
        bus.if_rst    = 1'b0;
        bus.id_rst    = 1'b0;
        bus.exe_rst   = 1'b0;
        bus.mem_rst   = 1'b0;
        bus.wb_rst    = 1'b0;
        bus.fwd_a_sel = sel_a_c;
        bus.fwd_b_sel = sel_b_c;
        bus.fwd_m     = fwd_m_c;
        if (!rst_n) begin
            // Clear every stage while reset is held.
            bus.if_rst    = 1'b1;
            bus.id_rst    = 1'b1;
            bus.exe_rst   = 1'b1;
            bus.mem_rst   = 1'b1;
            bus.wb_rst    = 1'b1;
            bus.fwd_a_sel = SEL_W'(FWD_RF);
            bus.fwd_b_sel = SEL_W'(FWD_RF);
            bus.fwd_m     = 1'b0;
        end else begin
            unique case (mode)
                MODE_HOLD: begin
                    bus.if_en  = 1'b0;
                    bus.id_en  = 1'b0;
                    bus.exe_en = 1'b0;
                    bus.mem_en = 1'b0;
                    bus.wb_en  = 1'b0;
                end
                MODE_FLUSH: begin
                    // Kill the two younger instructions; the fetch proceeds.
                    bus.id_rst  = 1'b1;
                    bus.exe_rst = 1'b1;
                end
                MODE_STALL: begin
                    bus.if_en   = 1'b0;
                    bus.id_en   = 1'b0;
                    bus.exe_rst = 1'b1;
                end
                default: ;
            endcase
        end
    end

    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_prev <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            step_prev <= bus.debug_step;
            if (mode == MODE_STALL && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
            if (mode == MODE_FLUSH && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign bus.mdu_busy  = mdu_busy;
    assign bus.stall_cnt = stall_cnt;
    assign bus.flush_cnt = flush_cnt;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench for hazard_fwd_unit: directed scenarios followed by
// randomized stimulus, all compared against a behavioural reference model.
module tb_hazard_fwd_unit;
    import hazard_fwd_unit_pkg::*;

    localparam int AW  = 5;
    localparam int NF  = 2;
    localparam int LAT = 4;
    localparam int CW  = 32;
    localparam longint CNT_MAX = 64'h0000_0000_FFFF_FFFF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_fwd_unit_if #(.ADDR_W(AW), .NUM_FWD(NF), .CNT_W(CW)) bus ();

    hazard_fwd_unit #(
        .ADDR_W  (AW),
        .NUM_FWD (NF),
        .MDU_LAT (LAT),
        .CNT_W   (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model state.
    bit     m_busy;
    int     m_left;
    int     m_dst;
    bit     m_prev;
    longint m_stall, m_flush;

    typedef struct {
        int     sel_a, sel_b;
        bit     fwd_m;
        bit [4:0] en, rst;  // {if, id, exe, mem, wb}
        bit     hold, flush, stall, issue;
    } exp_t;

    function automatic void model_reset();
        m_busy = 0; m_left = 0; m_dst = 0; m_prev = 0; m_stall = 0; m_flush = 0;
    endfunction

    // Index of the youngest stage writing addr, or -1.
    function automatic int find_stage(input int addr);
        for (int k = 0; k < NF; k++)
            if (bus.stg_wen[k] && int'(bus.stg_waddr[k*AW +: AW]) == addr) return k;
        return -1;
    endfunction

    function automatic exp_t predict();
        exp_t e;
        int   rs, rt, ka, kb;
        bit   need_a, need_b, lda, ldb, mdu_hit;
        rs = int'(bus.id_rs_addr);
        rt = int'(bus.id_rt_addr);
        ka = find_stage(rs);
        kb = find_stage(rt);
        need_a = bus.id_rs_used && rs != 0 && ka >= 0;
        need_b = bus.id_rt_used && rt != 0 && kb >= 0;
        lda = need_a && ka == 0 && bus.stg_is_load[0];
        ldb = need_b && kb == 0 && bus.stg_is_load[0];
        e.fwd_m = ldb && bus.id_is_store;
        e.sel_a = need_a ? ka + 1 : 0;
        e.sel_b = (need_b && !e.fwd_m) ? kb + 1 : 0;
        mdu_hit = m_busy && ((bus.id_rs_used && rs != 0 && rs == m_dst) ||
                             (bus.id_rt_used && rt != 0 && rt == m_dst) || bus.id_is_mdu);
        e.stall = lda || (ldb && !bus.id_is_store) || mdu_hit;
        e.hold  = bus.debug_en && !(bus.debug_step && !m_prev);
        e.flush = bus.branch_taken;
        e.issue = !e.hold && !e.flush && !e.stall && bus.id_is_mdu;
        if (e.hold)       begin e.en = 5'b00000; e.rst = 5'b00000; end
        else if (e.flush) begin e.en = 5'b11111; e.rst = 5'b01100; end
        else if (e.stall) begin e.en = 5'b00111; e.rst = 5'b00100; end
        else              begin e.en = 5'b11111; e.rst = 5'b00000; end
        return e;
    endfunction

    function automatic void model_advance(input exp_t e);
        if (!e.hold) begin
            if (e.flush) begin
                if (m_flush < CNT_MAX) m_flush++;
            end else if (e.stall) begin
                if (m_stall < CNT_MAX) m_stall++;
            end
            if (e.issue) begin
                m_busy = 1; m_left = LAT; m_dst = int'(bus.id_mdu_dst);
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) m_busy = 0;
            end
        end
        m_prev = bus.debug_step;
    endfunction

    // Checks every output against the model, then crosses one rising edge.
    task automatic step_cycle(input string tag);
        exp_t e;
        #2;
        e = predict();
        check({tag, ".sel_a"}, 64'(bus.fwd_a_sel), 64'(e.sel_a));
        check({tag, ".sel_b"}, 64'(bus.fwd_b_sel), 64'(e.sel_b));
        check({tag, ".fwd_m"}, 64'(bus.fwd_m), 64'(e.fwd_m));
        check({tag, ".en"}, 64'({bus.if_en, bus.id_en, bus.exe_en, bus.mem_en, bus.wb_en}), 64'(e.en));
        check({tag, ".rst"}, 64'({bus.if_rst, bus.id_rst, bus.exe_rst, bus.mem_rst, bus.wb_rst}), 64'(e.rst));
        check({tag, ".busy"}, 64'(bus.mdu_busy), 64'(m_busy));
        check({tag, ".stall_cnt"}, 64'(bus.stall_cnt), 64'(m_stall));
        check({tag, ".flush_cnt"}, 64'(bus.flush_cnt), 64'(m_flush));
        @(posedge clk);
        model_advance(e);
        #1;
    endtask

    task automatic set_idle();
        bus.debug_en = 0; bus.debug_step = 0;
        bus.id_rs_addr = '0; bus.id_rt_addr = '0;
        bus.id_rs_used = 0; bus.id_rt_used = 0;
        bus.id_is_store = 0; bus.id_is_mdu = 0; bus.id_mdu_dst = '0;
        bus.stg_wen = '0; bus.stg_waddr = '0; bus.stg_is_load = '0;
        bus.branch_taken = 0;
    endtask

    task automatic set_stage(input int k, input int addr, input bit is_load);
        bus.stg_wen[k] = 1'b1;
        bus.stg_waddr[k*AW +: AW] = AW'(addr);
        bus.stg_is_load[k] = is_load;
    endtask

    task automatic rand_inputs();
        bus.debug_en     = ($urandom_range(0, 7) == 0);
        bus.debug_step   = $urandom_range(0, 1);
        bus.id_rs_addr   = AW'($urandom_range(0, 7));
        bus.id_rt_addr   = AW'($urandom_range(0, 7));
        bus.id_rs_used   = $urandom_range(0, 1);
        bus.id_rt_used   = $urandom_range(0, 1);
        bus.id_is_store  = $urandom_range(0, 1);
        bus.id_is_mdu    = ($urandom_range(0, 5) == 0);
        bus.id_mdu_dst   = AW'($urandom_range(0, 7));
        bus.branch_taken = ($urandom_range(0, 5) == 0);
        for (int k = 0; k < NF; k++) begin
            bus.stg_wen[k] = $urandom_range(0, 1);
            bus.stg_waddr[k*AW +: AW] = AW'($urandom_range(0, 7));
            bus.stg_is_load[k] = $urandom_range(0, 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int     stalls, en_cycles;
        longint s0, f0;

        // Reset: a live forwarding match must still be masked.
        set_idle();
        model_reset();
        bus.id_rs_used = 1; bus.id_rs_addr = 5'd3; set_stage(0, 3, 0);
        #3;
        check("rst.en", 64'({bus.if_en, bus.id_en, bus.exe_en, bus.mem_en, bus.wb_en}), 64'h1f);
        check("rst.rst", 64'({bus.if_rst, bus.id_rst, bus.exe_rst, bus.mem_rst, bus.wb_rst}), 64'h1f);
        check("rst.sel_a", 64'(bus.fwd_a_sel), 64'd0);
        check("rst.busy", 64'(bus.mdu_busy), 64'd0);
        check("rst.cnts", 64'({bus.stall_cnt, bus.flush_cnt}), 64'd0);
        #9 rst_n = 1;
        set_idle();
        @(posedge clk); #1;

        // ALU result in EXE, then only in MEM.
        bus.id_rs_used = 1; bus.id_rs_addr = 5'd3; set_stage(0, 3, 0);
        #1 check("add_exe.sel_a", 64'(bus.fwd_a_sel), 64'd1);
        check("add_exe.id_en", 64'(bus.id_en), 64'd1);
        step_cycle("add_exe");
        bus.stg_wen = '0; set_stage(1, 3, 0);
        #1 check("add_mem.sel_a", 64'(bus.fwd_a_sel), 64'd2);
        step_cycle("add_mem");

        // Load-use on rs, then the load reaches MEM.
        set_idle();
        bus.id_rs_used = 1; bus.id_rs_addr = 5'd4; set_stage(0, 4, 1);
        #1 check("lw_use.stall", 64'({bus.if_en, bus.id_en, bus.exe_rst}), 64'b001);
        step_cycle("lw_use");
        set_idle();
        bus.id_rs_used = 1; bus.id_rs_addr = 5'd4; set_stage(1, 4, 1);
        #1 check("lw_mem.sel_a", 64'(bus.fwd_a_sel), 64'd2);
        check("lw_mem.stall_cnt", 64'(bus.stall_cnt), 64'd1);
        step_cycle("lw_mem");

        // Load feeding store data vs store address.
        set_idle();
        bus.id_is_store = 1; bus.id_rt_used = 1; bus.id_rt_addr = 5'd5;
        bus.id_rs_used = 1; bus.id_rs_addr = 5'd1; set_stage(0, 5, 1);
        #1 check("sw_rt.fwd_m", 64'({bus.fwd_m, bus.fwd_b_sel, bus.id_en}), 64'b1001);
        step_cycle("sw_rt");
        bus.id_rt_addr = 5'd2; bus.id_rs_addr = 5'd5;
        #1 check("sw_rs.id_en", 64'(bus.id_en), 64'd0);
        step_cycle("sw_rs");

        // MDU result dependency: exactly LAT stall cycles.
        set_idle();
        bus.id_is_mdu = 1; bus.id_mdu_dst = 5'd8;
        step_cycle("mdu_issue");
        set_idle();
        bus.id_rs_used = 1; bus.id_rs_addr = 5'd8;
        stalls = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.id_en) break;
            stalls++;
            step_cycle("mdu_wait");
        end
        check("mdu.stalls", 64'(stalls), 64'(LAT));
        check("mdu.busy_fell", 64'(bus.mdu_busy), 64'd0);
        step_cycle("mdu_go");

        // MDU writing $0 never blocks a $0 reader.
        set_idle();
        bus.id_is_mdu = 1; bus.id_mdu_dst = 5'd0;
        step_cycle("mdu0_issue");
        set_idle();
        bus.id_rs_used = 1; bus.id_rt_used = 1;
        #1 check("mdu0.no_stall", 64'({bus.mdu_busy, bus.id_en}), 64'b11);
        for (int i = 0; i < LAT; i++) step_cycle("mdu0_drain");

        // Branch flush overrides a concurrent load stall.
        set_idle();
        s0 = m_stall; f0 = m_flush;
        bus.id_rs_used = 1; bus.id_rs_addr = 5'd4; set_stage(0, 4, 1);
        bus.branch_taken = 1;
        #1 check("flush.ctl", 64'({bus.if_en, bus.if_rst, bus.id_rst, bus.exe_rst}), 64'b1011);
        step_cycle("flush");
        set_idle();
        #1 check("flush.flush_cnt", 64'(bus.flush_cnt), 64'(f0 + 1));
        check("flush.stall_cnt", 64'(bus.stall_cnt), 64'(s0));
        step_cycle("post_flush");

        // Debug hold, then a step held high for five cycles.
        bus.debug_en = 1;
        step_cycle("dbg_hold");
        step_cycle("dbg_hold");
        bus.debug_step = 1;
        en_cycles = 0;
        for (int i = 0; i < 5; i++) begin
            #1 if (bus.exe_en) en_cycles++;
            step_cycle("dbg_step");
        end
        check("dbg.en_cycles", 64'(en_cycles), 64'd1);
        set_idle();
        step_cycle("dbg_off");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            step_cycle("rand");
        end

        // Asynchronous reset in the middle of an MDU op.
        set_idle();
        bus.id_is_mdu = 1; bus.id_mdu_dst = 5'd9;
        step_cycle("mdu_rst_issue");
        set_idle();
        step_cycle("mdu_rst_busy");
        #3 rst_n = 0;
        #1 check("mdu_rst.busy", 64'(bus.mdu_busy), 64'd0);
        check("mdu_rst.cnts", 64'({bus.stall_cnt, bus.flush_cnt}), 64'd0);
        model_reset();
        #2 rst_n = 1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) step_cycle("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
